// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: burst-locking arbiter sharing one FIFO write port among NREQ requesters.
// Define FIFO_ARB_FIXED_PRIO_EN for lowest-index-wins priority instead of round-robin.
module fifo_wr_arb #(
  parameter int NREQ   = 4,
  parameter int DWIDTH = 32,
  parameter int BURST  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*DWIDTH-1:0]  wdata_in,
  output logic [NREQ-1:0]         ack,
  input  logic                    fifo_full,
  output logic                    fifo_we,
  output logic [DWIDTH-1:0]       fifo_wdata,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    busy
);

  localparam int OW = $clog2(NREQ);
  localparam int CW = $clog2(BURST + 1);
  localparam int unsigned NR = NREQ;
  localparam logic [CW-1:0] LAST = CW'(BURST - 1);

  typedef enum logic {ST_IDLE, ST_BURST} state_t;

  state_t        state_q, state_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [OW-1:0] winner;
  logic          found;
  logic          exit_burst;
  int unsigned   base;
  int unsigned   idx;

  logic [DWIDTH-1:0] words [NREQ];
  for (genvar g = 0; g < NREQ; g++) begin : g_words
    assign words[g] = wdata_in[g*DWIDTH +: DWIDTH];
  end

`ifdef FIFO_ARB_FIXED_PRIO_EN
  assign base = '0;
`else
  logic [OW-1:0] ptr_q, ptr_d, next_ptr;

  assign next_ptr = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + OW'(1);
  assign ptr_d    = exit_burst ? next_ptr : ptr_q;
  assign base     = 32'(ptr_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`endif

  // Scan upward from base, wrapping; the first requester found wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned k = 0; k < NR; k++) begin
      idx = (base + k) % NR;
      if (!found && req[OW'(idx)]) begin
        winner = OW'(idx);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    exit_burst = 1'b0;
    fifo_we    = 1'b0;
    fifo_wdata = '0;
    ack        = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (found) begin
          owner_d = winner;
          cnt_d   = '0;
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        fifo_wdata   = words[owner_q];
        fifo_we      = req[owner_q] & ~fifo_full;
        ack[owner_q] = fifo_we;
        if (fifo_we) cnt_d = cnt_q + CW'(1);
        // A stall keeps ownership; only a completed burst or a dropped req releases.
        if ((fifo_we && cnt_q == LAST) || !req[owner_q]) begin
          exit_burst = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy  = (state_q == ST_BURST);
  assign owner = owner_q;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Self-checking bench for fifo_wr_arb: directed scenarios plus randomized traffic
// against a word-level reference model with a DEPTH=4 FIFO model.
`timescale 1ns/1ps
module tb_fifo_wr_arb;
  localparam int NREQ = 4, DW = 32, BURST = 4, DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic [NREQ*DW-1:0] wdata_in = '0;
  logic [NREQ-1:0] ack;
  logic fifo_full = 1'b0;
  logic fifo_we;
  logic [DW-1:0] fifo_wdata;
  logic [1:0] owner;
  logic busy;

  fifo_wr_arb #(.NREQ(NREQ), .DWIDTH(DW), .BURST(BURST)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wdata_in(wdata_in), .ack(ack),
    .fifo_full(fifo_full), .fifo_we(fifo_we), .fifo_wdata(fifo_wdata),
    .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [DW-1:0] rq [NREQ][$];   // pending words per requester
  logic [NREQ-1:0] en = '0;      // requester willing to assert req
  logic [DW-1:0] fq [$];         // FIFO contents
  logic re = 1'b1;

  bit m_busy;
  int m_owner, m_left, m_ptr;
  logic exp_we;
  logic [NREQ-1:0] exp_ack;
  logic [DW-1:0] exp_wdata;
  logic [39:0] got, want;

  int cyc;
  int wl_cyc [$];
  int wl_own [$];
  logic [DW-1:0] wl_dat [$];

  function automatic int pick(logic [NREQ-1:0] r, int p);
`ifdef FIFO_ARB_FIXED_PRIO_EN
    for (int k = 0; k < NREQ; k++) if (r[k]) return k;
`else
    for (int k = 0; k < NREQ; k++) if (r[(p + k) % NREQ]) return (p + k) % NREQ;
`endif
    return -1;
  endfunction

  task automatic setup_cycle();
    for (int i = 0; i < NREQ; i++) begin
      req[i] = en[i] && (rq[i].size() > 0);
      wdata_in[i*DW +: DW] = (rq[i].size() > 0) ? rq[i][0] : (32'hDEAD_0000 + 32'(i));
    end
    fifo_full = (fq.size() >= DEPTH);
    exp_we = 1'b0;
    exp_ack = '0;
    exp_wdata = '0;
    if (m_busy) begin
      exp_we = req[m_owner] && !fifo_full;
      exp_ack[m_owner] = exp_we;
      exp_wdata = wdata_in[m_owner*DW +: DW];
    end
    @(negedge clk);
    got  = {fifo_we, ack, fifo_wdata, busy, busy ? owner : 2'd0};
    want = {exp_we, exp_ack, exp_wdata, m_busy, m_busy ? 2'(m_owner) : 2'd0};
  endtask

  task automatic finish_cycle();
    int w;
    @(posedge clk);
    if (re && fq.size() > 0) void'(fq.pop_front());
    if (exp_we) begin
      fq.push_back(exp_wdata);
      wl_cyc.push_back(cyc);
      wl_own.push_back(m_owner);
      wl_dat.push_back(exp_wdata);
      void'(rq[m_owner].pop_front());
    end
    if (!m_busy) begin
      w = pick(req, m_ptr);
      if (w >= 0) begin
        m_busy = 1;
        m_owner = w;
        m_left = BURST;
      end
    end else begin
      if (exp_we) m_left--;
      if ((exp_we && m_left == 0) || !req[m_owner]) begin
        m_busy = 0;
        m_ptr = (m_owner + 1) % NREQ;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic clear_env();
    for (int i = 0; i < NREQ; i++) rq[i].delete();
    fq.delete();
    wl_cyc.delete();
    wl_own.delete();
    wl_dat.delete();
    en = '0;
    req = '0;
    re = 1'b1;
    m_busy = 0;
    m_owner = 0;
    m_left = 0;
    m_ptr = 0;
    cyc = 1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_env();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_env();
    for (int i = 0; i < NREQ; i++) rq[i].push_back(32'h5A5A_0000 + 32'(i));
    en = '1;
    setup_cycle();
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL reset_state got=%h want=%h", got, want);
    end
    do_reset();
    for (int k = 0; k < 8; k++) begin
      rq[0].push_back(32'h0A00 + 32'(k));
      rq[1].push_back(32'h0B00 + 32'(k));
    end
    en = 4'b0011;
    for (int n = 0; n < 40 && rq[1].size() > 6; n++) begin
      setup_cycle();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL reset_pre cyc=%0d got=%h want=%h", cyc, got, want);
      end
      finish_cycle();
    end
    total++;
    if (rq[1].size() != 6 || busy !== 1'b1 || owner !== 2'd1) begin
      bad++;
      $display("FAIL reset_midburst_setup left=%0d busy=%b owner=%0d want 6/1/1", rq[1].size(), busy, owner);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, fifo_we, ack} !== 6'b0) begin
      bad++;
      $display("FAIL reset_async busy=%b we=%b ack=%b want 0", busy, fifo_we, ack);
    end
    @(negedge clk);
    total++;
    if (fifo_we !== 1'b0 || ack !== '0 || fifo_wdata !== '0) begin
      bad++;
      $display("FAIL reset_hold we=%b ack=%b wd=%h want 0", fifo_we, ack, fifo_wdata);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    fq.delete();
    wl_cyc.delete();
    wl_own.delete();
    wl_dat.delete();
    m_busy = 0;
    m_ptr = 0;
    m_owner = 0;
    cyc = 1;
    for (int n = 0; n < 4; n++) begin
      setup_cycle();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL reset_post cyc=%0d got=%h want=%h", cyc, got, want);
      end
      if (cyc == 2) begin
        total++;
        if (busy !== 1'b1 || owner !== 2'd0) begin
          bad++;
          $display("FAIL reset_first_grant busy=%b owner=%0d want 1/0", busy, owner);
        end
      end
      finish_cycle();
    end
  endtask

  task automatic test_single();
    do_reset();
    for (int k = 10; k <= 15; k++) rq[2].push_back(32'(k));
    en = 4'b0100;
    for (int n = 0; n < 12; n++) begin
      setup_cycle();
      total++;
      if (got !== want || (busy && owner !== 2'd2)) begin
        bad++;
        $display("FAIL single cyc=%0d got=%h want=%h", cyc, got, want);
      end
      if (cyc == 6) begin
        total++;
        if (busy !== 1'b0) begin
          bad++;
          $display("FAIL single_idle busy=%b want 0", busy);
        end
      end
      finish_cycle();
    end
    total++;
    if (wl_dat.size() != 6) begin
      bad++;
      $display("FAIL single_count writes=%0d want 6", wl_dat.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        total++;
        if (wl_dat[k] !== 32'(10 + k) || wl_cyc[k] != 2 + k + k / 4) begin
          bad++;
          $display("FAIL single_write k=%0d data=%0d cyc=%0d want %0d/%0d", k, wl_dat[k], wl_cyc[k], 10 + k, 2 + k + k / 4);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < NREQ; i++)
      for (int k = 0; k < 8; k++) rq[i].push_back(32'(i * 100 + k));
    en = 4'b1111;
    for (int n = 0; n < 25; n++) begin
      setup_cycle();
      total++;
      if (got !== want || !$onehot0(ack)) begin
        bad++;
        $display("FAIL rr cyc=%0d got=%h want=%h", cyc, got, want);
      end
      finish_cycle();
    end
    total++;
    if (wl_own.size() != 20) begin
      bad++;
      $display("FAIL rr_count writes=%0d want 20", wl_own.size());
    end else begin
      for (int k = 0; k < 20; k++) begin
        total++;
        if (wl_own[k] != (k / 4) % 4) begin
          bad++;
          $display("FAIL rr_order k=%0d owner=%0d want %0d", k, wl_own[k], (k / 4) % 4);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] exp_d [4];
    int exp_c [4];
    exp_d = '{32'h100, 32'h101, 32'h102, 32'h103};
    exp_c = '{2, 3, 9, 10};
    do_reset();
    fq.push_back(32'h1);
    fq.push_back(32'h2);
    for (int k = 0; k < 4; k++) rq[1].push_back(exp_d[k]);
    en = 4'b0010;
    for (int n = 0; n < 12; n++) begin
      re = (cyc >= 8);
      setup_cycle();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL bp cyc=%0d got=%h want=%h", cyc, got, want);
      end
      if (cyc >= 4 && cyc <= 8) begin
        total++;
        if (fifo_we !== 1'b0 || busy !== 1'b1 || owner !== 2'd1) begin
          bad++;
          $display("FAIL bp_stall cyc=%0d we=%b busy=%b owner=%0d want 0/1/1", cyc, fifo_we, busy, owner);
        end
      end
      finish_cycle();
    end
    total++;
    if (wl_dat.size() != 4) begin
      bad++;
      $display("FAIL bp_count writes=%0d want 4", wl_dat.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        total++;
        if (wl_dat[k] !== exp_d[k] || wl_cyc[k] != exp_c[k]) begin
          bad++;
          $display("FAIL bp_write k=%0d data=%h cyc=%0d want %h/%0d", k, wl_dat[k], wl_cyc[k], exp_d[k], exp_c[k]);
        end
      end
    end
  endtask

  task automatic test_early_release();
    do_reset();
    rq[3].push_back(32'h300);
    rq[3].push_back(32'h301);
    for (int k = 0; k < 4; k++) rq[1].push_back(32'h110 + 32'(k));
    en = 4'b1000;
    for (int n = 0; n < 10; n++) begin
      if (cyc == 2) en = 4'b1010;
      setup_cycle();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL early cyc=%0d got=%h want=%h", cyc, got, want);
      end
      if (cyc == 4) begin
        total++;
        if (fifo_we !== 1'b0 || busy !== 1'b1 || owner !== 2'd3) begin
          bad++;
          $display("FAIL early_drop we=%b busy=%b owner=%0d want 0/1/3", fifo_we, busy, owner);
        end
      end
      if (cyc == 5) begin
        total++;
        if (busy !== 1'b0) begin
          bad++;
          $display("FAIL early_idle busy=%b want 0", busy);
        end
      end
      if (cyc == 6) begin
        total++;
        if (busy !== 1'b1 || owner !== 2'd1 || fifo_we !== 1'b1 || fifo_wdata !== 32'h110) begin
          bad++;
          $display("FAIL early_regrant busy=%b owner=%0d we=%b wd=%h want 1/1/1/110", busy, owner, fifo_we, fifo_wdata);
        end
      end
      finish_cycle();
    end
  endtask

`ifdef FIFO_ARB_FIXED_PRIO_EN
  task automatic test_fixed_prio();
    do_reset();
    for (int k = 0; k < 12; k++) rq[1].push_back(32'h1000 + 32'(k));
    for (int k = 0; k < 4; k++) rq[3].push_back(32'h3000 + 32'(k));
    en = 4'b1010;
    for (int n = 0; n < 16; n++) begin
      setup_cycle();
      total++;
      if (got !== want || ack[3] !== 1'b0) begin
        bad++;
        $display("FAIL fixed cyc=%0d got=%h want=%h", cyc, got, want);
      end
      finish_cycle();
    end
    total++;
    if (wl_own.size() != 12) begin
      bad++;
      $display("FAIL fixed_count writes=%0d want 12", wl_own.size());
    end else begin
      for (int k = 0; k < 12; k++) begin
        total++;
        if (wl_own[k] != 1 || wl_cyc[k] != 2 + k + k / 4) begin
          bad++;
          $display("FAIL fixed_write k=%0d owner=%0d cyc=%0d want 1/%0d", k, wl_own[k], wl_cyc[k], 2 + k + k / 4);
        end
      end
    end
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (rq[i].size() < 3 && $urandom_range(3) == 0) rq[i].push_back($urandom);
        if ($urandom_range(9) == 0) en[i] = ~en[i];
      end
      re = ($urandom_range(1) == 0);
      setup_cycle();
      total++;
      if (got !== want || !$onehot0(ack) || (fifo_we && fifo_full)) begin
        bad++;
        $display("FAIL random cyc=%0d got=%h want=%h full=%b", cyc, got, want, fifo_full);
      end
      finish_cycle();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    test_reset();
    test_single();
`ifndef FIFO_ARB_FIXED_PRIO_EN
    test_round_robin();
`endif
    test_backpressure();
    test_early_release();
`ifdef FIFO_ARB_FIXED_PRIO_EN
    test_fixed_prio();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arb.md
# fifo_wr_arb

Burst-locking write arbiter that shares one synchronous FIFO write port between NREQ requesters. It sits directly in front of the team's `syn_fifo`, driving the FIFO's `we`/`wdata` and observing its `full`. Each requester raises `req` with data and gets a per-word `ack`. Ownership is granted for up to BURST words before it is re-arbitrated.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `DWIDTH`, 32: data width; must equal the FIFO data width.
- `BURST`, 4: maximum words written per grant, ≥1.

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req` input NREQ: per-requester write request; a requester holds it high while it has a word.
- `wdata_in` input NREQ*DWIDTH: requester i data on bits [i*DWIDTH +: DWIDTH].
- `ack` output NREQ: one-hot; word of the owner taken this cycle.
- `fifo_full` input 1: FIFO `full`.
- `fifo_we` output 1: FIFO `we`.
- `fifo_wdata` output DWIDTH: FIFO `wdata`.
- `owner` output $clog2(NREQ): index of the current grant holder; valid when `busy`=1.
- `busy` output 1: high in BURST state.

## Operation
- States: IDLE and BURST.
- **IDLE:**
  - No writes; `fifo_we`=0 and `ack`=0.
  - If any `req` is high, select a winner, register it into `owner`, clear `cnt`, and go to BURST next cycle.
- **Round-robin selection:** scan from `ptr` upward, wrapping modulo NREQ. The first set `req` wins.
- **BURST outputs (combinational from registered `owner`):**
  - `fifo_we` = `req[owner]` & !`fifo_full`.
  - `ack[owner]` = `fifo_we`; all other `ack` bits are 0.
  - `fifo_wdata` = `wdata_in` slice of `owner`, driven regardless of `fifo_we`.
- **BURST counting:** each write increments `cnt` (width $clog2(BURST+1)).
- **BURST exit to IDLE** when either condition holds:
  - a write occurs with `cnt`==BURST-1;
  - `req[owner]`==0 (no write that cycle).
- **On exit:** `ptr` ← (`owner`+1) mod NREQ.
- **Back-pressure:** `fifo_full`=1 stalls BURST. There is no write and no `cnt` change, ownership is kept, and there is no timeout.
- **Requester drops `req` while stalled:** exit to IDLE; nothing is written.
- **Outside BURST:** `fifo_wdata` = 0.
- **Requester contract:** data must be stable while `req`=1 and `ack`=0. A requester advances to its next word after a cycle with `ack`=1.

## Timing
- **Reset values:**
  - state = IDLE, `ptr`=0, `owner`=0, `cnt`=0.
  - `busy`=0, `fifo_we`=0, `ack`=0, `fifo_wdata`=0.
- **Reset mid-burst:** abandons the burst immediately (asynchronous). No write occurs while `rst_n`=0.
- **Latency:** `req` rising in IDLE → first `fifo_we` on the next edge's cycle, i.e. 1 arbitration cycle.
- **Throughput:**
  - Peak: BURST words per BURST+1 cycles for a single continuous requester.
  - The grant is always released after BURST words, even with no competition.
- **No lookahead:** `fifo_full` is sampled combinationally in the same cycle; `fifo_we` is never asserted while `fifo_full`=1.
- **Simultaneous events:** a write on the last beat and `req[owner]` dropping in the same cycle are consistent. The write completes, then the block goes to IDLE.

## Configuration
- `FIFO_ARB_FIXED_PRIO_EN` defined:
  - Fixed priority; the lowest index wins.
  - `ptr` is not implemented; BURST limit and exit rules are unchanged.
- `FIFO_ARB_FIXED_PRIO_EN` undefined (default): round-robin as described in Operation.

## Test plan
All scenarios use NREQ=4, BURST=4, DWIDTH=32, with a `syn_fifo` DEPTH=4 attached.

- **Reset:** assert `rst_n`=0 mid-burst with `req`=4'b0011.
  - `fifo_we`, `ack` and `busy` go 0 immediately.
  - After release, the first grant goes to requester 0 (`ptr`=0).
- **Single requester:** `req[2]` held with data 10, 11, 12, 13, 14, 15; FIFO drained continuously.
  - Writes 10–13 occur in cycles 2–5.
  - Cycle 6 is IDLE.
  - Writes 14–15 occur in cycles 7–8.
  - `owner`=2 throughout.
- **Round-robin:** `req`=4'b1111 held.
  - Grant order is 0, 1, 2, 3, 0, with 4 words each.
  - `ack` is one-hot in every cycle.
- **Back-pressure:** owner 1, FIFO fills after 2 writes, `re`=0 for 5 cycles.
  - `fifo_we`=0 and `cnt`=2 during the stall.
  - When `re` resumes, the remaining 2 words are written in order.
- **Early release:** owner 3 drops `req` after 2 acks.
  - The block is in IDLE the next cycle.
  - `ptr`=0; a pending `req[1]` is granted after the arbitration cycle.
- **`FIFO_ARB_FIXED_PRIO_EN` defined, `req`=4'b1010 held:**
  - Grants alternate 1, 1, 1, …; requester 3 is never acked.
  - Each grant is 4 words followed by 1 IDLE cycle.
